// File: rtl/pio_read_scheduler.sv
// Round-robin read arbiter plus periodic poller sharing one Avalon-MM input PIO
// slave with registered readdata (1-cycle latency, no waitrequest).
module pio_read_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 2,
    parameter int POLL_PERIOD = 1000,
    parameter int POLL_ADDR   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         pio_address,
    input  logic [DATA_W-1:0]         pio_readdata,
    output logic [DATA_W-1:0]         snapshot,
    output logic                      change_pulse,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD = (POLL_PERIOD > 0) ? CNT_W'(POLL_PERIOD - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   rr_last;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_hit;
    logic [ADDR_W-1:0]  grant_addr;
    logic [IDX_W-1:0]   src_idx;
    logic               src_poll;
    logic [CNT_W-1:0]   poll_cnt;
    logic               poll_pending;
    logic               poll_expire;
    logic               snap_valid;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offs);
        rr_index = IDX_W'((int'(base) + offs) % NUM_REQ);
    endfunction

    assign poll_expire = (POLL_PERIOD != 0) && (poll_cnt == '0);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    // Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i];
    // req_ready is a one-hot, combinational grant raised only in IDLE with no poll pending.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        grant_idx  = '0;
        grant_hit  = 1'b0;
        grant_addr = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_hit && req_valid[rr_index(rr_last, k)]) begin
                grant_hit = 1'b1;
                grant_idx = rr_index(rr_last, k);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_idx) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
        case (state)
            IDLE: begin
                if (poll_pending) begin
                    state_next = ISSUE;
                end else if (grant_hit) begin
                    state_next = ISSUE;
                    if (!reset) req_ready[grant_idx] = 1'b1;
                end
            end
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_last      <= IDX_W'(NUM_REQ - 1);
            poll_cnt     <= RELOAD;
            poll_pending <= 1'b0;
            snap_valid   <= 1'b0;
            snapshot     <= '0;
            change_pulse <= 1'b0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            pio_address  <= '0;
            src_poll     <= 1'b0;
            src_idx      <= '0;
        end else begin
            state        <= state_next;
            rsp_valid    <= '0;
            change_pulse <= 1'b0;
            if (POLL_PERIOD != 0) poll_cnt <= poll_expire ? RELOAD : poll_cnt - 1'b1;
            // An expiry landing while a poll is still pending merges into that one poll.
            if (poll_expire) poll_pending <= 1'b1;
            else if (state == IDLE && poll_pending) poll_pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_pending) begin
                        pio_address <= ADDR_W'(POLL_ADDR);
                        src_poll    <= 1'b1;
                    end else if (grant_hit) begin
                        pio_address <= grant_addr;
                        src_poll    <= 1'b0;
                        src_idx     <= grant_idx;
                        rr_last     <= grant_idx;
                    end
                end
                CAPTURE: begin
                    if (!src_poll) begin
                        rsp_data           <= pio_readdata;
                        rsp_valid[src_idx] <= 1'b1;
                    end else if (!snap_valid || pio_readdata != snapshot) begin
                        snapshot     <= pio_readdata;
                        change_pulse <= 1'b1;
                        snap_valid   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_read_scheduler.sv
// Bench for pio_read_scheduler: three instances (poll period 1000, 8 and 0) sharing
// one PIO memory, checked every cycle against a transaction-level model plus directed literals.
module tb_pio_read_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rv [3];
    logic [7:0]  ra [3];
    logic [31:0] readdata [3];
    logic [31:0] mem [4];
    wire  [3:0]  req_ready [3];
    wire  [3:0]  rsp_valid [3];
    wire  [31:0] rsp_data [3];
    wire  [1:0]  pio_address [3];
    wire  [31:0] snapshot [3];
    wire         change_pulse [3];
    wire         busy [3];
    wire  [1:0]  state_dbg [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pio_read_scheduler #(
            .NUM_REQ(4), .DATA_W(32), .ADDR_W(2),
            .POLL_PERIOD(g == 0 ? 1000 : (g == 1 ? 8 : 0)), .POLL_ADDR(0)
        ) u_dut (
            .clk(clk), .reset(reset), .req_valid(rv[g]), .req_addr(ra[g]),
            .req_ready(req_ready[g]), .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]),
            .pio_address(pio_address[g]), .pio_readdata(readdata[g]),
            .snapshot(snapshot[g]), .change_pulse(change_pulse[g]), .busy(busy[g]),
            .state_dbg(state_dbg[g])
        );
    end

    // PIO slave: readdata registered from the address presented in the previous cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) readdata[k] <= mem[pio_address[k]];
    end

    typedef struct {
        int          pp;
        int          cnt;
        bit          pending;
        int          left;      // cycles still to go for the outstanding read, 0 = none
        int          src;       // -1 = poll
        int          rr_last;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] snap;
        bit          snap_valid;
        logic [31:0] rdata;
        logic [3:0]  rvalid;
        bit          change;
    } model_t;

    model_t mdl [3];

    function automatic int pp_of(input int k);
        return (k == 0) ? 1000 : ((k == 1) ? 8 : 0);
    endfunction

    function automatic logic [3:0] exp_ready(input model_t m, input logic rst, input logic [3:0] v);
        if (rst || m.left != 0 || m.pending) return 4'd0;
        for (int o = 1; o <= 4; o++) begin
            int i;
            i = (m.rr_last + o) % 4;
            if (v[i]) return 4'd1 << i;
        end
        return 4'd0;
    endfunction

    function automatic model_t step(input model_t m, input logic rst, input logic [3:0] v, input logic [7:0] a);
        model_t n;
        logic [3:0] g;
        bit expire;
        n = m;
        n.rvalid = 4'd0;
        n.change = 1'b0;
        if (rst) begin
            n.cnt = (m.pp > 0) ? m.pp - 1 : 0;
            n.pending = 1'b0; n.left = 0; n.src = 0; n.rr_last = 3; n.addr = 2'd0;
            n.data = 32'd0; n.snap = 32'd0; n.snap_valid = 1'b0; n.rdata = 32'd0;
            return n;
        end
        g = exp_ready(m, rst, v);
        expire = (m.pp > 0) && (m.cnt == 0);
        if (m.pp > 0) n.cnt = expire ? m.pp - 1 : m.cnt - 1;
        if (m.left == 0) begin
            if (m.pending) begin
                n.addr = 2'd0; n.src = -1; n.left = 2; n.pending = 1'b0;
            end else if (g != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    if (g[i]) begin
                        n.src = i; n.rr_last = i; n.addr = a[i*2 +: 2];
                    end
                end
                n.left = 2;
            end
        end else if (m.left == 2) begin
            n.data = mem[m.addr];
            n.left = 1;
        end else begin
            n.left = 0;
            if (m.src >= 0) begin
                n.rdata = m.data;
                n.rvalid = 4'd1 << m.src;
            end else if (!m.snap_valid || m.data != m.snap) begin
                n.snap = m.data; n.snap_valid = 1'b1; n.change = 1'b1;
            end
        end
        if (expire) n.pending = 1'b1;
        return n;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (started) begin
                chk("req_ready", k, 32'(req_ready[k]), 32'(exp_ready(mdl[k], reset, rv[k])));
                chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(mdl[k].rvalid));
                chk("rsp_data", k, rsp_data[k], mdl[k].rdata);
                chk("pio_address", k, 32'(pio_address[k]), 32'(mdl[k].addr));
                chk("snapshot", k, snapshot[k], mdl[k].snap);
                chk("change_pulse", k, 32'(change_pulse[k]), 32'(mdl[k].change));
                chk("busy", k, 32'(busy[k]), 32'(mdl[k].left != 0));
                chk("state_idle", k, 32'(state_dbg[k] == 2'd0), 32'(mdl[k].left == 0));
            end
            mdl[k] = step(mdl[k], reset, rv[k], ra[k]);
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 4'd0;
            ra[k] = 8'd0;
            mdl[k].pp = pp_of(k);
        end
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("reset_req_ready", 0, 32'(req_ready[0]), 32'd0);
        chk("reset_busy", 0, 32'(busy[0]), 32'd0);
        chk("reset_snapshot", 1, snapshot[1], 32'd0);

        // Single request from requester 0.
        @(posedge clk); #1 reset = 1'b0;
        mem[0] = 32'hA5A5_0001; rv[0] = 4'b0001; ra[0] = 8'd0;
        @(negedge clk);
        chk("single_grant", 0, 32'(req_ready[0]), 32'h1);
        @(posedge clk); #1 rv[0] = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("single_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1);
        chk("single_rsp_data", 0, rsp_data[0], 32'hA5A5_0001);

        // Reset while a request from requester 2 sits in CAPTURE.
        @(posedge clk); #1;
        mem[2] = 32'hDEAD_0002; rv[0] = 4'b0100; ra[0] = 8'b10_00_00_00;
        @(negedge clk);
        chk("rst_grant", 0, 32'(req_ready[0]), 32'h4);
        @(posedge clk); #1 rv[0] = 4'd0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy_capture", 0, 32'(busy[0]), 32'h1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
        chk("rst_rsp_data", 0, rsp_data[0], 32'd0);
        chk("rst_addr", 0, 32'(pio_address[0]), 32'd0);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);

        // Round robin with all four requesters held valid.
        @(posedge clk); #1;
        rv[0] = 4'b1111; ra[0] = {2'd3, 2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + 32'(i);
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            if (g < 5) chk("rr_grant", 0, 32'(req_ready[0]), 32'h1 << (g % 4));
            if (g > 0) begin
                chk("rr_rsp_valid", 0, 32'(rsp_valid[0]), 32'h1 << ((g - 1) % 4));
                chk("rr_rsp_data", 0, rsp_data[0], 32'h1000_0000 + 32'((g - 1) % 4));
            end
            @(posedge clk); #1;
            if (g == 4) rv[0] = 4'd0;
            repeat (2) @(posedge clk);
        end

        // Poll change detection on the period-8 instance.
        mem[0] = 32'd5;
        pulse_reset();
        wait_cyc(10); @(negedge clk);
        chk("poll1_busy", 1, 32'(busy[1]), 32'h1);
        chk("poll1_no_pulse_yet", 1, 32'(change_pulse[1]), 32'd0);
        wait_cyc(11); @(negedge clk);
        chk("poll1_pulse", 1, 32'(change_pulse[1]), 32'h1);
        chk("poll1_snapshot", 1, snapshot[1], 32'd5);
        wait_cyc(12); @(negedge clk);
        chk("poll1_pulse_end", 1, 32'(change_pulse[1]), 32'd0);
        wait_cyc(19); @(negedge clk);
        chk("poll2_same_no_pulse", 1, 32'(change_pulse[1]), 32'd0);
        chk("poll2_snapshot", 1, snapshot[1], 32'd5);
        wait_cyc(20); mem[0] = 32'd6;
        wait_cyc(27); @(negedge clk);
        chk("poll3_pulse", 1, 32'(change_pulse[1]), 32'h1);
        chk("poll3_snapshot", 1, snapshot[1], 32'd6);

        // Poll pending in the same cycle requester 2 asks.
        wait_cyc(32);
        mem[3] = 32'hCAFE_0003; rv[1] = 4'b0100; ra[1] = 8'b00_11_00_00;
        @(negedge clk);
        chk("prio_ready_blocked", 1, 32'(req_ready[1]), 32'd0);
        wait_cyc(33); @(negedge clk);
        chk("prio_poll_addr", 1, 32'(pio_address[1]), 32'd0);
        chk("prio_poll_busy", 1, 32'(busy[1]), 32'h1);
        wait_cyc(35); @(negedge clk);
        chk("prio_grant2", 1, 32'(req_ready[1]), 32'h4);
        chk("prio_poll_no_rsp", 1, 32'(rsp_valid[1]), 32'd0);
        wait_cyc(36); rv[1] = 4'd0;
        wait_cyc(38); @(negedge clk);
        chk("prio_rsp_valid", 1, 32'(rsp_valid[1]), 32'h4);
        chk("prio_rsp_data", 1, rsp_data[1], 32'hCAFE_0003);

        // Polling disabled instance left idle for a long stretch.
        wait_cyc(38 + 10000); @(negedge clk);
        chk("nopoll_addr", 2, 32'(pio_address[2]), 32'd0);
        chk("nopoll_snapshot", 2, snapshot[2], 32'd0);
        chk("nopoll_pulse", 2, 32'(change_pulse[2]), 32'd0);
        chk("nopoll_busy", 2, 32'(busy[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
